// File: rtl/cpu_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single fixed-latency memory port.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN switches contention policy from data-first to alternating.
module cpu_mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [3:0] LAT    = 4'(MEM_LATENCY);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;  // 1 = data side won the most recent grant
  logic       grant_d;
  logic       done;

  always_comb begin
    grant_d = d_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_valid && d_valid) grant_d = ~last_grant;
`endif
  end

  assign done = (state != IDLE) && (cnt == LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (i_valid || d_valid) begin
            state      <= grant_d ? BUSY_D : BUSY_I;
            last_grant <= grant_d;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // The memory port mirrors the granted requester for the whole access; strobe only on its first cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    case (state)
      BUSY_I: begin
        mem_en   = (cnt == 4'd0);
        mem_addr = i_addr;
      end
      BUSY_D: begin
        mem_en    = (cnt == 4'd0);
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
      default: ;
    endcase
  end

  assign i_ready = done && (state == BUSY_I);
  assign d_ready = done && (state == BUSY_D);
  assign i_rdata = i_ready ? mem_rdata : 32'd0;
  assign d_rdata = d_ready ? mem_rdata : 32'd0;

  // The grant flag must always name the side currently being served.
  a_grant_tracks_state: assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_D) |-> last_grant);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: per-cycle vector table on a latency-1 instance,
// plus hand sequences for contention, latency-3 timing and reset during an access.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_wstrb = 4'd0;
  logic [31:0] mem_rdata = 32'd0;

  logic        i_ready1, d_ready1, mem_en1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_wstrb1;
  logic        i_ready3, d_ready3, mem_en3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_wstrb3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata)
  );

  cpu_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready3), .i_rdata(i_rdata3),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic [31:0] mr;
    logic        en;
    logic [31:0] ma;
    logic [31:0] mw;
    logic [3:0]  ms;
    logic        ir;
    logic [31:0] ird;
    logic        dr;
    logic [31:0] drd;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step_drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    d_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // rst iv ia dv da dw ds mr | en ma mw ms ir ird dr drd
    vec[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[3]  = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h13, 1'b0, 32'h0};
    vec[4]  = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, 32'h55, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, 32'h55, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h2004, 32'hDEADBEEF, 4'hF, 32'h55, 1'b0, 32'h2004, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1, 32'h55};
    vec[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h2004, 32'hDEADBEEF, 4'hF, 32'h55, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 32'h0, 4'h0, 32'hA5A5, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h3000, 32'h0, 4'h0, 32'hA5A5, 1'b1, 32'h3000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h3000, 32'h0, 4'h0, 32'hA5A5, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'hA5A5};
    vec[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 4'h0, 32'h11, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[13] = '{1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 32'h0, 4'h0, 32'h11, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[14] = '{1'b0, 1'b1, 32'h80, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h11};
    vec[15] = '{1'b0, 1'b1, 32'h80, 1'b0, 32'h40, 32'h1234, 4'h3, 32'h22, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[16] = '{1'b0, 1'b1, 32'h80, 1'b0, 32'h40, 32'h1234, 4'h3, 32'h22, 1'b1, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vec[17] = '{1'b0, 1'b0, 32'h80, 1'b0, 32'h40, 32'h1234, 4'h3, 32'h22, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h22, 1'b0, 32'h0};
    vec[18] = '{1'b0, 1'b0, 32'h80, 1'b0, 32'h40, 32'h1234, 4'h3, 32'h22, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst = vec[k].rst; i_valid = vec[k].iv; i_addr = vec[k].ia;
      d_valid = vec[k].dv; d_addr = vec[k].da; d_wdata = vec[k].dw;
      d_wstrb = vec[k].ds; mem_rdata = vec[k].mr;
      #1;
      chk($sformatf("v%0d mem_en", k),    32'(mem_en1),    32'(vec[k].en));
      chk($sformatf("v%0d mem_addr", k),  mem_addr1,       vec[k].ma);
      chk($sformatf("v%0d mem_wdata", k), mem_wdata1,      vec[k].mw);
      chk($sformatf("v%0d mem_wstrb", k), 32'(mem_wstrb1), 32'(vec[k].ms));
      chk($sformatf("v%0d i_ready", k),   32'(i_ready1),   32'(vec[k].ir));
      chk($sformatf("v%0d i_rdata", k),   i_rdata1,        vec[k].ird);
      chk($sformatf("v%0d d_ready", k),   32'(d_ready1),   32'(vec[k].dr));
      chk($sformatf("v%0d d_rdata", k),   d_rdata1,        vec[k].drd);
    end

    // Continuous contention: four completions on the latency-1 instance.
    do_reset();
    i_addr = 32'h900; d_addr = 32'hA00; d_wdata = 32'h0; d_wstrb = 4'h0;
    i_valid = 1'b1; d_valid = 1'b1;
    begin
      int i_grants;
      i_grants = 0;
      for (int t = 0; t < 4; t++) begin
        logic got;
        logic gd;
        logic exp_d;
        got = 1'b0; gd = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
          step_drive();
          #1;
          if (i_ready1 || d_ready1) begin
            got = 1'b1;
            gd = d_ready1;
          end
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d = (t % 2) == 0;
`else
        exp_d = 1'b1;
`endif
        chk($sformatf("contend t%0d completed", t), 32'(got), 32'd1);
        chk($sformatf("contend t%0d grant_is_d", t), 32'(gd), 32'(exp_d));
        if (got && !gd) i_grants++;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("contend i grant total", i_grants, 32'd2);
`else
      chk("contend i grant total", i_grants, 32'd0);
`endif
    end
    i_valid = 1'b0; d_valid = 1'b0;

    // Latency-3 load: one strobe, ready four cycles after the sampling cycle.
    do_reset();
    d_addr = 32'h500; d_wstrb = 4'h0; mem_rdata = 32'h77;
    d_valid = 1'b1;
    begin
      int en_cnt, en_cyc, rdy_cnt, rdy_cyc;
      logic [31:0] rdy_data;
      en_cnt = 0; en_cyc = -1; rdy_cnt = 0; rdy_cyc = -1; rdy_data = 32'h0;
      for (int c = 1; c <= 8; c++) begin
        step_drive();
        #1;
        if (mem_en3) begin en_cnt++; if (en_cyc < 0) en_cyc = c; d_valid = 1'b0; end
        if (d_ready3) begin rdy_cnt++; if (rdy_cyc < 0) begin rdy_cyc = c; rdy_data = d_rdata3; end end
      end
      chk("lat3 mem_en count", en_cnt, 32'd1);
      chk("lat3 mem_en cycle", en_cyc, 32'd1);
      chk("lat3 d_ready count", rdy_cnt, 32'd1);
      chk("lat3 d_ready cycle", rdy_cyc, 32'd4);
      chk("lat3 d_rdata", rdy_data, 32'h77);
    end

    // Reset while cnt=1 in BUSY_D, then the held request is served anew.
    do_reset();
    d_addr = 32'h600; d_wdata = 32'h0; d_wstrb = 4'h0; mem_rdata = 32'h99;
    d_valid = 1'b1;
    step_drive(); #1;
    chk("rst seq busy mem_en", 32'(mem_en3), 32'd1);
    step_drive(); #1;
    chk("rst seq cnt1 addr", mem_addr3, 32'h600);
    rst = 1'b1;
    #1;
    chk("rst seq outputs zero",
        {mem_addr3, mem_wdata3, d_rdata3, i_rdata3},
        32'h0);
    chk("rst seq ctrl zero",
        32'({mem_en3, mem_wstrb3, d_ready3, i_ready3}), 32'd0);
    step_drive();
    rst = 1'b0;
    begin
      int en_cnt, rdy_cnt, rdy_cyc;
      en_cnt = 0; rdy_cnt = 0; rdy_cyc = -1;
      for (int c = 1; c <= 10; c++) begin
        step_drive();
        #1;
        if (mem_en3) en_cnt++;
        if (d_ready3) begin rdy_cnt++; if (rdy_cyc < 0) rdy_cyc = c; d_valid = 1'b0; end
      end
      chk("rst seq restart mem_en count", en_cnt, 32'd1);
      chk("rst seq restart d_ready count", rdy_cnt, 32'd1);
      chk("rst seq restart d_ready cycle", rdy_cyc, 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
